// File: rtl/uart_pkg.sv
// uart_pkg: frame constants and FSM state encoding
// shared by the UART transmitter and receiver.
package uart_pkg;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: received-byte valid/ack handshake
// plus the receiver's error pulses and busy flag.
interface uart_rx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] dout_byte;
  logic                 dout_valid;
  logic                 dout_ack;
  logic                 frame_err;
  logic                 overrun_err;
  logic                 busy;

  modport master (
    output dout_byte,
    output dout_valid,
    output frame_err,
    output overrun_err,
    output busy,
    input  dout_ack
  );

  modport slave (
    input  dout_byte,
    input  dout_valid,
    input  frame_err,
    input  overrun_err,
    input  busy,
    output dout_ack
  );

endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchronizer for the serial line,
// reset to the idle level so reset never looks like a start bit.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk_x,
  input  logic rst_p,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_x or posedge rst_p) begin
    if (rst_p) begin
      sync_q <= {2{IDLE_LEVEL}};
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx_top.sv
// uart_rx_top: 8N1 UART receiver with valid/ack byte output.
// Define UART_RX_SYNC_EN to pass ser_in through a 2-flop synchronizer.
module uart_rx_top
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic      clk_x,
  input  logic      rst_p,
  input  logic      ser_in,
  uart_rx_if.master rx
);

  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT) + 1;

  localparam logic [CW-1:0] CNT_BIT =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID =
    CW'((HALF > 0) ? HALF - 1 : 0);
  localparam logic [2:0] LAST_BIT =
    3'(DATA_BITS - 1);

  logic rx_s;

`ifdef UART_RX_SYNC_EN
  uart_rx_sync u_sync (
    .clk_x (clk_x),
    .rst_p (rst_p),
    .d_i   (ser_in),
    .q_o   (rx_s)
  );
`else
  assign rx_s = ser_in;
`endif

  uart_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] byte_q, byte_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;

  always_ff @(posedge clk_x or posedge rst_p) begin
    if (rst_p) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    if (valid_q && rx.dout_ack) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          bcnt_d = '0;
          // no mid-bit offset: this sample is the start sample
          if (HALF == 0) begin
            state_d = DATA;
            cnt_d   = CNT_BIT;
          end else begin
            state_d = START;
            cnt_d   = CNT_MID;
          end
        end
      end
      START: begin
        if (cnt_q == '0) begin
          if (!rx_s) begin
            state_d = DATA;
            cnt_d   = CNT_BIT;
            bcnt_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          cnt_d   = CNT_BIT;
          bcnt_d  = bcnt_q + 3'd1;
          if (bcnt_q == LAST_BIT) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          if (rx_s) begin
            byte_d  = shift_q;
            valid_d = 1'b1;
            ovr_d   = valid_q && !rx.dout_ack;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BRK;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      BRK: begin
        // a held-low line must go high before a new start
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rx.dout_byte   = byte_q;
  assign rx.dout_valid  = valid_q;
  assign rx.frame_err   = ferr_q;
  assign rx.overrun_err = ovr_q;
  assign rx.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_top.sv
// tb_uart_rx_top: directed bench for uart_rx_top with
// CLKS_PER_BIT=1 (dut1) and CLKS_PER_BIT=4 (dut4).
module tb_uart_rx_top;

`ifdef UART_RX_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  typedef struct {
    logic [7:0] din;
    logic       stop;
    logic [7:0] exp_byte;
    logic       exp_valid;
    int         exp_ferr;
  } vec_t;

  logic clk_x = 1'b0;
  logic rst_p;
  logic ser1;
  logic ser4;

  int checks  = 0;
  int errors  = 0;
  int ferr1_n = 0;
  int ovr1_n  = 0;
  int ferr4_n = 0;
  int ovr4_n  = 0;

  uart_rx_if rx1 ();
  uart_rx_if rx4 ();

  uart_rx_top #(.CLKS_PER_BIT(1)) dut1 (
    .clk_x  (clk_x),
    .rst_p  (rst_p),
    .ser_in (ser1),
    .rx     (rx1.master)
  );

  uart_rx_top #(.CLKS_PER_BIT(4)) dut4 (
    .clk_x  (clk_x),
    .rst_p  (rst_p),
    .ser_in (ser4),
    .rx     (rx4.master)
  );

  always #5 clk_x = ~clk_x;

  always @(negedge clk_x) begin
    if (rx1.frame_err)   ferr1_n++;
    if (rx1.overrun_err) ovr1_n++;
    if (rx4.frame_err)   ferr4_n++;
    if (rx4.overrun_err) ovr4_n++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic logic [9:0] frm(
      input logic [7:0] b, input logic stop);
    return {stop, b, 1'b0};
  endfunction

  task automatic send1(input logic [7:0] b,
                       input logic stop);
    logic [9:0] f;
    f = frm(b, stop);
    for (int k = 0; k < 10; k++) begin
      ser1 = f[k];
      @(negedge clk_x);
    end
    ser1 = 1'b1;
    repeat (L + 1) @(negedge clk_x);
  endtask

  task automatic send4(input logic [7:0] b);
    logic [9:0] f;
    f = frm(b, 1'b1);
    for (int k = 0; k < 10; k++) begin
      ser4 = f[k];
      repeat (4) @(negedge clk_x);
    end
    ser4 = 1'b1;
    repeat (L + 2) @(negedge clk_x);
  endtask

  task automatic ack1();
    rx1.dout_ack = 1'b1;
    @(negedge clk_x);
    rx1.dout_ack = 1'b0;
  endtask

  initial begin
    vec_t       tbl [5];
    logic [9:0] fr;
    logic [7:0] got [$];
    int         e;
    int         f0;
    int         o0;
    int         f4;
    int         o4;

    tbl[0] = '{8'h55, 1'b1, 8'h55, 1'b1, 0};
    tbl[1] = '{8'h00, 1'b1, 8'h00, 1'b1, 0};
    tbl[2] = '{8'hFF, 1'b1, 8'hFF, 1'b1, 0};
    tbl[3] = '{8'hC3, 1'b0, 8'hFF, 1'b0, 1};
    tbl[4] = '{8'h96, 1'b1, 8'h96, 1'b1, 0};

    rst_p = 1'b1;
    ser1  = 1'b1;
    ser4  = 1'b1;
    rx1.dout_ack = 1'b0;
    rx4.dout_ack = 1'b0;

    @(negedge clk_x);
    chk("rst_byte", 32'(rx1.dout_byte), 32'h00);
    chk("rst_valid", 32'(rx1.dout_valid), 0);
    chk("rst_ferr", 32'(rx1.frame_err), 0);
    chk("rst_ovr", 32'(rx1.overrun_err), 0);
    chk("rst_busy", 32'(rx1.busy), 0);
    chk("rst_busy4", 32'(rx4.busy), 0);
    repeat (2) @(negedge clk_x);
    rst_p = 1'b0;
    repeat (L + 2) @(negedge clk_x);

    // A5: per-cycle busy/valid around the start sample
    fr = frm(8'hA5, 1'b1);
    for (int k = 0; k < 12 + L; k++) begin
      ser1 = (k < 10) ? fr[k] : 1'b1;
      @(negedge clk_x);
      e = k - L;
      if (e >= 0) begin
        chk("lat_busy", 32'(rx1.busy), 32'(e <= 8));
        chk("lat_valid", 32'(rx1.dout_valid),
            32'(e >= 9));
      end
    end
    chk("lat_byte", 32'(rx1.dout_byte), 32'hA5);

    // back-to-back 01, 80 with ack held high
    f0 = ferr1_n;
    o0 = ovr1_n;
    rx1.dout_ack = 1'b1;
    fr = frm(8'h01, 1'b1);
    for (int k = 0; k < 24 + L; k++) begin
      if (k == 10) fr = frm(8'h80, 1'b1);
      ser1 = (k < 20) ? fr[k % 10] : 1'b1;
      @(negedge clk_x);
      if (k >= L && rx1.dout_valid)
        got.push_back(rx1.dout_byte);
    end
    rx1.dout_ack = 1'b0;
    chk("b2b_cnt", 32'(got.size()), 2);
    chk("b2b_0", 32'((got.size() > 0) ? got[0] : 8'h00),
        32'h01);
    chk("b2b_1", 32'((got.size() > 1) ? got[1] : 8'h00),
        32'h80);
    chk("b2b_ferr", 32'(ferr1_n - f0), 0);
    chk("b2b_ovr", 32'(ovr1_n - o0), 0);

    for (int i = 0; i < 5; i++) begin
      ack1();
      f0 = ferr1_n;
      send1(tbl[i].din, tbl[i].stop);
      chk($sformatf("tbl%0d_byte", i),
          32'(rx1.dout_byte), 32'(tbl[i].exp_byte));
      chk($sformatf("tbl%0d_valid", i),
          32'(rx1.dout_valid), 32'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d_ferr", i),
          32'(ferr1_n - f0), 32'(tbl[i].exp_ferr));
      chk($sformatf("tbl%0d_busy", i),
          32'(rx1.busy), 0);
    end

    // 3C with stop=0, line held low 5 more cycles
    ack1();
    f0 = ferr1_n;
    o0 = ovr1_n;
    fr = frm(8'h3C, 1'b0);
    for (int k = 0; k < 20 + L; k++) begin
      ser1 = (k < 10) ? fr[k] : (k < 15) ? 1'b0 : 1'b1;
      @(negedge clk_x);
      e = k - L;
      if (e == 14) begin
        chk("brk_busy", 32'(rx1.busy), 1);
        chk("brk_valid", 32'(rx1.dout_valid), 0);
      end
    end
    chk("fe_cnt", 32'(ferr1_n - f0), 1);
    chk("fe_ovr", 32'(ovr1_n - o0), 0);
    chk("fe_valid", 32'(rx1.dout_valid), 0);
    chk("fe_busy", 32'(rx1.busy), 0);
    chk("fe_byte", 32'(rx1.dout_byte), 32'h96);

    // overrun: 11 then 22 without ack
    o0 = ovr1_n;
    send1(8'h11, 1'b1);
    chk("ov_byte1", 32'(rx1.dout_byte), 32'h11);
    chk("ov_ovr1", 32'(ovr1_n - o0), 0);
    send1(8'h22, 1'b1);
    chk("ov_byte2", 32'(rx1.dout_byte), 32'h22);
    chk("ov_valid2", 32'(rx1.dout_valid), 1);
    chk("ov_ovr2", 32'(ovr1_n - o0), 1);
    ack1();
    chk("ov_ackclr", 32'(rx1.dout_valid), 0);

    // completion in the same cycle as an accepting ack
    send1(8'h44, 1'b1);
    chk("sim_v44", 32'(rx1.dout_valid), 1);
    o0 = ovr1_n;
    fr = frm(8'h55, 1'b1);
    for (int k = 0; k < 11 + L; k++) begin
      ser1 = (k < 10) ? fr[k] : 1'b1;
      rx1.dout_ack = (k == 9 + L);
      @(negedge clk_x);
    end
    rx1.dout_ack = 1'b0;
    chk("sim_byte", 32'(rx1.dout_byte), 32'h55);
    chk("sim_valid", 32'(rx1.dout_valid), 1);
    chk("sim_ovr", 32'(ovr1_n - o0), 0);

    // CLKS_PER_BIT=4: one-cycle glitch, then 5A
    f4 = ferr4_n;
    o4 = ovr4_n;
    ser4 = 1'b0;
    @(negedge clk_x);
    ser4 = 1'b1;
    repeat (L) @(negedge clk_x);
    chk("fs_busy_hi", 32'(rx4.busy), 1);
    repeat (3) @(negedge clk_x);
    chk("fs_busy_lo", 32'(rx4.busy), 0);
    chk("fs_valid", 32'(rx4.dout_valid), 0);
    chk("fs_ferr", 32'(ferr4_n - f4), 0);
    send4(8'h5A);
    chk("c4_byte", 32'(rx4.dout_byte), 32'h5A);
    chk("c4_valid", 32'(rx4.dout_valid), 1);
    chk("c4_busy", 32'(rx4.busy), 0);
    chk("c4_ferr", 32'(ferr4_n - f4), 0);
    chk("c4_ovr", 32'(ovr4_n - o4), 0);

    // reset after the 4th data bit of FF
    fr = frm(8'hFF, 1'b1);
    for (int k = 0; k <= 4 + L; k++) begin
      ser1 = (k < 10) ? fr[k] : 1'b1;
      @(negedge clk_x);
    end
    chk("mid_busy", 32'(rx1.busy), 1);
    rst_p = 1'b1;
    #1;
    chk("ar_byte", 32'(rx1.dout_byte), 32'h00);
    chk("ar_valid", 32'(rx1.dout_valid), 0);
    chk("ar_busy", 32'(rx1.busy), 0);
    chk("ar_valid4", 32'(rx4.dout_valid), 0);
    ser1 = 1'b1;
    repeat (2) @(negedge clk_x);
    rst_p = 1'b0;
    repeat (L + 2) @(negedge clk_x);
    f0 = ferr1_n;
    send1(8'h0F, 1'b1);
    chk("pr_byte", 32'(rx1.dout_byte), 32'h0F);
    chk("pr_valid", 32'(rx1.dout_valid), 1);
    chk("pr_ferr", 32'(ferr1_n - f0), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
